// File: rtl/gb_timer_pkg.sv
// DMG divider/timer shared definitions: register offsets, tap mapping, FSM states.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package gb_timer_pkg;

   // Default bus address of DIV; TIMA, TMA and TAC follow at +1, +2, +3.
   localparam logic [15:0] BASE_ADDR_DEFAULT = 16'hFF04;

   // Register offsets from the base address.
   localparam logic [1:0] REG_DIV  = 2'd0;
   localparam logic [1:0] REG_TIMA = 2'd1;
   localparam logic [1:0] REG_TMA  = 2'd2;
   localparam logic [1:0] REG_TAC  = 2'd3;

   // Clocks that TIMA holds 0x00 after the overflow edge before the reload clk.
   localparam logic [1:0] OVF_DELAY = 2'd3;

   // TIMA overflow/reload sequencing.
   typedef enum logic [1:0] {
      ST_COUNT  = 2'd0,
      ST_OVF    = 2'd1,
      ST_RELOAD = 2'd2
   } tima_state_e;

   // TAC[1:0] selects which divider bit clocks TIMA.
   function automatic logic [3:0] tac_tap(input logic [1:0] sel);
      logic [3:0] tap;
      case (sel)
         2'b00:   tap = 4'd9;
         2'b01:   tap = 4'd3;
         2'b10:   tap = 4'd5;
         default: tap = 4'd7;
      endcase
      return tap;
   endfunction

endpackage

// File: rtl/gb_timer_if.sv
// CPU-side register bus of the timer (address, write data, strobes) plus the irq line.
// Latency: n/a (signal bundle only).
// Backpressure: none; every access completes in the clk it is presented.
interface gb_timer_if;
   logic [15:0] addr;
   logic [7:0]  din;
   logic        wr;
   logic        rd;
   logic        irq_timer;

   modport master (
      output addr,
      output din,
      output wr,
      output rd,
      input  irq_timer
   );

   modport slave (
      input  addr,
      input  din,
      input  wr,
      input  rd,
      output irq_timer
   );
endinterface

// File: rtl/gb_timer_prescaler.sv
// 16-bit system divider with tap mux and falling-edge tick detect (GB_TIMER_GLITCH_EN picks DMG glitch mode).
// Latency: tick is high the clk after the divider edge that drops the tapped bit.
// Backpressure: none; free-running, DIV writes restart it.
module gb_timer_prescaler
   import gb_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       div_wr,       // DIV write commits on this edge
   input  logic [2:0] tac,          // TAC as currently registered
   input  logic [1:0] tap_sel_nxt,  // TAC[1:0] as it will be after this edge
   output logic [7:0] div_val,      // upper divider byte, read back as DIV
   output logic       tick          // one-clk TIMA increment request
);

   logic [15:0] sysclk;

   // Free-running divider; any DIV write clears the whole 16-bit count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sysclk <= 16'h0000;
      end else if (div_wr) begin
         sysclk <= 16'h0000;
      end else begin
         sysclk <= sysclk + 16'h0001;
      end
   end

   assign div_val = sysclk[15:8];

`ifdef GB_TIMER_GLITCH_EN
   logic tsig;
   logic tsig_q;

   // The enable is folded into the tick source, so disabling the timer, moving
   // the tap or clearing the divider can all drop tsig and count once.
   assign tsig = tac[2] & sysclk[tac_tap(tac[1:0])];

   // Previous-clk copy of tsig for the falling-edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tsig_q <= 1'b0;
      end else begin
         tsig_q <= tsig;
      end
   end

   assign tick = tsig_q & ~tsig;
`else
   logic tap_q;

   // Sample the bit the tap will select after this edge, so a TAC tap change
   // never looks like an edge. A DIV clear restarts the phase without a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q <= 1'b0;
      end else if (div_wr) begin
         tap_q <= 1'b0;
      end else begin
         tap_q <= sysclk[tac_tap(tap_sel_nxt)];
      end
   end

   assign tick = tac[2] & tap_q & ~sysclk[tac_tap(tac[1:0])];
`endif

endmodule

// File: rtl/gb_timer.sv
// DMG DIV/TIMA/TMA/TAC register block with overflow reload and timer irq (GB_TIMER_GLITCH_EN selects tick variant).
// Latency: reads combinational; TIMA reload and one-clk irq_timer come 4 clk after the FF->00 edge.
// Backpressure: none; writes commit on the clk edge they are presented, dout floats when not read.
module gb_timer
   import gb_timer_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   gb_timer_if.slave  bus,
   output wire  [7:0] dout   // shared CPU read bus, high-Z unless this block is read
);

   logic [15:0]  off;
   logic         hit;
   logic [1:0]   reg_sel;
   logic         div_wr;
   logic         tima_wr;
   logic         tma_wr;
   logic         tac_wr;

   logic [7:0]   tima;
   logic [7:0]   tima_nxt;
   logic [7:0]   tma;
   logic [7:0]   tma_nxt;
   logic [2:0]   tac;
   logic [2:0]   tac_nxt;
   logic [1:0]   cnt;
   logic [1:0]   cnt_nxt;
   tima_state_e  state;
   tima_state_e  state_nxt;

   logic [7:0]   div_val;
   logic         tick;
   logic [7:0]   rdat;

   // Only the four addresses starting at BASE_ADDR decode; the subtract keeps
   // this correct for any base, aligned or not.
   assign off     = bus.addr - BASE_ADDR;
   assign hit     = (off[15:2] == 14'd0);
   assign reg_sel = off[1:0];

   assign div_wr  = bus.wr & hit & (reg_sel == REG_DIV);
   assign tima_wr = bus.wr & hit & (reg_sel == REG_TIMA);
   assign tma_wr  = bus.wr & hit & (reg_sel == REG_TMA);
   assign tac_wr  = bus.wr & hit & (reg_sel == REG_TAC);

   // Post-edge values of TMA and TAC, so a same-clk write is seen by the
   // reload path and by the prescaler's tap sampling.
   assign tma_nxt = tma_wr ? bus.din      : tma;
   assign tac_nxt = tac_wr ? bus.din[2:0] : tac;

   gb_timer_prescaler u_prescaler (
      .clk         (clk),
      .rst_n       (rst_n),
      .div_wr      (div_wr),
      .tac         (tac),
      .tap_sel_nxt (tac_nxt[1:0]),
      .div_val     (div_val),
      .tick        (tick)
   );

   // TMA and TAC are plain CPU-written registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tma <= 8'h00;
         tac <= 3'b000;
      end else begin
         tma <= tma_nxt;
         tac <= tac_nxt;
      end
   end

   // TIMA, overflow delay count and sequencing state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_COUNT;
         cnt   <= 2'd0;
         tima  <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tima  <= tima_nxt;
      end
   end

   // Next TIMA/state: CPU writes beat ticks, the reload clk follows TMA only.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tima_nxt  = tima;
      case (state)
         ST_COUNT: begin
            if (tima_wr) begin
               tima_nxt = bus.din;
            end else if (tick) begin
               if (tima == 8'hFF) begin
                  tima_nxt  = 8'h00;
                  state_nxt = ST_OVF;
                  cnt_nxt   = OVF_DELAY;
               end else begin
                  tima_nxt = tima + 8'h01;
               end
            end
         end
         ST_OVF: begin
            if (tima_wr) begin
               // CPU write aborts the pending reload and its irq.
               tima_nxt  = bus.din;
               state_nxt = ST_COUNT;
               cnt_nxt   = 2'd0;
            end else if (cnt == 2'd0) begin
               tima_nxt  = tma_nxt;
               state_nxt = ST_RELOAD;
            end else begin
               cnt_nxt = cnt - 2'd1;
               if (tick) begin
                  tima_nxt = tima + 8'h01;
               end
            end
         end
         ST_RELOAD: begin
            // TIMA already holds TMA; a TMA write this clk is passed through,
            // TIMA writes and ticks are dropped.
            tima_nxt  = tma_nxt;
            state_nxt = ST_COUNT;
         end
         default: begin
            state_nxt = ST_COUNT;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // The reload clk is exactly the irq clk.
   assign bus.irq_timer = (state == ST_RELOAD);

   // Register read mux; TAC's unused upper bits read as ones.
   always_comb begin
      rdat = 8'h00;
      case (reg_sel)
         REG_DIV:  rdat = div_val;
         REG_TIMA: rdat = tima;
         REG_TMA:  rdat = tma;
         REG_TAC:  rdat = {5'b11111, tac};
         default:  rdat = 8'h00;
      endcase
   end

   assign dout = (bus.rd & hit) ? rdat : 8'hzz;

endmodule
